// File: rtl/sync_updown_counter.sv
// sync_updown_counter: synchronous up/down modulo counter with load, clear, wrap/saturate and boundary event pulses
module sync_updown_counter #(
  parameter int                WIDTH    = 4,
  parameter longint unsigned   MAX      = (64'd1 << WIDTH) - 64'd1,
  parameter bit                SATURATE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_cnt,
  output logic [WIDTH-1:0] o_cnt_bar,
  output logic             o_tc,
  output logic             o_ovf,
  output logic             o_udf
);
  if (WIDTH < 1 || WIDTH > 32 || MAX < 64'd1 || MAX > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_param
    $fatal(1, "sync_updown_counter: illegal WIDTH/MAX");
  end
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);
  logic [WIDTH-1:0] r_cnt;
  logic             r_ovf;
  logic             r_udf;
  logic             w_at_max;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_next;
  logic             w_ovf_next;
  logic             w_udf_next;
  assign w_at_max  = r_cnt == MAXV;
  assign w_at_zero = r_cnt == '0;
  // next count and event flags, priority clear > load > step > hold
  always_comb begin
    w_next     = r_cnt;
    w_ovf_next = 1'b0;
    w_udf_next = 1'b0;
    if (i_clear) w_next = '0;
    else if (i_load) w_next = (i_din > MAXV) ? MAXV : i_din;
    else if (i_en && i_up) begin
      w_next     = w_at_max ? (SATURATE ? MAXV : '0) : r_cnt + WIDTH'(1);
      w_ovf_next = w_at_max;
    end else if (i_en) begin
      w_next     = w_at_zero ? (SATURATE ? '0 : MAXV) : r_cnt - WIDTH'(1);
      w_udf_next = w_at_zero;
    end
  end
  // state register with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_cnt <= w_next;
      r_ovf <= w_ovf_next;
      r_udf <= w_udf_next;
    end
  end
  assign o_cnt     = r_cnt;
  assign o_cnt_bar = ~r_cnt;
  assign o_tc      = i_en & (i_up ? w_at_max : w_at_zero);
  assign o_ovf     = r_ovf;
  assign o_udf     = r_udf;
endmodule

// File: tb/tb_sync_updown_counter.sv
// tb_sync_updown_counter: scoreboard bench for wrap (sel 0) and saturate (sel 1) counters with MAX=9
module tb_sync_updown_counter;
  typedef struct {
    bit       sel;
    bit [3:0] cnt;
    bit       ovf;
    bit       udf;
    bit       tc;
    int       idx;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [3:0] din = 4'd0;
  logic [3:0] cnt_a, cnt_bar_a, cnt_b, cnt_bar_b;
  logic       tc_a, ovf_a, udf_a, tc_b, ovf_b, udf_b;
  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  int         idx = 0;
  sync_updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_wrap (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_clear(clear), .i_load(load), .i_din(din),
    .o_cnt(cnt_a), .o_cnt_bar(cnt_bar_a), .o_tc(tc_a), .o_ovf(ovf_a), .o_udf(udf_a)
  );
  sync_updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b1)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_clear(clear), .i_load(load), .i_din(din),
    .o_cnt(cnt_b), .o_cnt_bar(cnt_bar_b), .o_tc(tc_b), .o_ovf(ovf_b), .o_udf(udf_b)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int n, input logic [3:0] got, input logic [3:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s vec%0d: got %h expected %h", name, n, got, want);
    end
  endtask
  task automatic step(input bit s, input bit r, input bit c, input bit l, input bit e, input bit u,
                      input logic [3:0] d, input logic [3:0] ec, input bit eo, input bit eu, input bit et);
    @(negedge clk);
    rst = r; clear = c; load = l; en = e; up = u; din = d;
    q.push_back('{s, ec, eo, eu, et, idx});
    idx++;
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("cnt", x.idx, x.sel ? cnt_b : cnt_a, x.cnt);
      chk("cnt_bar", x.idx, x.sel ? cnt_bar_b : cnt_bar_a, ~x.cnt);
      chk("ovf", x.idx, {3'b0, x.sel ? ovf_b : ovf_a}, {3'b0, x.ovf});
      chk("udf", x.idx, {3'b0, x.sel ? udf_b : udf_a}, {3'b0, x.udf});
      chk("tc", x.idx, {3'b0, x.sel ? tc_b : tc_a}, {3'b0, x.tc});
    end
  end
  initial begin
    step(0, 0, 0, 0, 1, 1, 4'd0, 4'd0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 4'd0, 4'd0, 0, 0, 0);
    for (int i = 1; i <= 12; i++)
      step(0, 1, 0, 0, 1, 1, 4'd0, 4'(i % 10), i == 10, 0, (i % 10) == 9);
    step(0, 1, 1, 0, 1, 0, 4'd0, 4'd0, 0, 0, 1);
    step(0, 1, 0, 0, 1, 0, 4'd0, 4'd9, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 4'd0, 4'd9, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1, 4'd5, 4'd0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 1, 4'd5, 4'd5, 0, 0, 0);
    step(0, 1, 0, 1, 0, 1, 4'hF, 4'd9, 0, 0, 0);
    step(0, 1, 0, 0, 1, 1, 4'd0, 4'd0, 1, 0, 0);
    step(0, 1, 0, 1, 0, 1, 4'd6, 4'd6, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 4'd3, 4'd0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 1, 4'd0, 4'd1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 1, 4'd8, 4'd8, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1, 4'd0, 4'd9, 0, 0, 1);
    step(1, 1, 0, 0, 1, 1, 4'd0, 4'd9, 1, 0, 1);
    step(1, 1, 0, 0, 1, 1, 4'd0, 4'd9, 1, 0, 1);
    step(1, 1, 0, 1, 0, 0, 4'd1, 4'd1, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0, 4'd0, 4'd0, 0, 0, 1);
    step(1, 1, 0, 0, 1, 0, 4'd0, 4'd0, 0, 1, 1);
    step(1, 1, 0, 0, 1, 0, 4'd0, 4'd0, 0, 1, 1);
    step(1, 1, 0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 1, 4'hC, 4'd9, 0, 0, 0);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sync_updown_counter.md
# sync_updown_counter

Parametrised, fully synchronous up/down counter with programmable modulus, parallel load, synchronous clear and a wrap-or-saturate mode. It supersedes the ripple T-flip-flop counter: every bit is clocked by `clk`, so `cnt` changes only on the `clk` rising edge. It also adds direction control, terminal-count detection and overflow/underflow event pulses. It is the general-purpose event/interval counter for timers and sequencers in the design.

## Interface
- `WIDTH`, 4: counter width in bits. Legal range is 1..32.
- `MAX`, 2**WIDTH-1: terminal value. The count range is 0..MAX. Legal range is 1..2**WIDTH-1; an elaboration-time check fails on an illegal value.
- `SATURATE`, 0: end-of-range behaviour. 0 wraps (MAX->0 going up, 0->MAX going down); 1 holds at the end value.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `en` in 1: count enable. One step per cycle while high.
- `up` in 1: direction. 1 counts up, 0 counts down. Sampled only when a count step occurs.
- `clear` in 1: synchronous clear to 0.
- `load` in 1: parallel load of `din`.
- `din` in WIDTH: load value.
- `cnt` out WIDTH: registered count.
- `cnt_bar` out WIDTH: bitwise inverse of `cnt` (combinational).
- `tc` out 1: combinational terminal count, `en & (up ? cnt==MAX : cnt==0)`.
- `ovf` out 1: registered one-cycle pulse. Set when an up-step is taken with `cnt==MAX`.
- `udf` out 1: registered one-cycle pulse. Set when a down-step is taken with `cnt==0`.

## Operation
- Per-edge priority, highest first: `rst`==0, then `clear`, then `load`, then `en`, then hold.
- Reset (`rst`==0): `cnt`=0, `ovf`=0, `udf`=0. Hence `cnt_bar`=all ones and `tc`=`en & ~up`.
- Clear: `cnt`<=0, `ovf`<=0, `udf`<=0.
- Load: `cnt`<=`din` if `din`<=MAX, otherwise `cnt`<=MAX (clamp). `ovf`<=0, `udf`<=0.
- Load and clear suppress counting in the same cycle; there is no step and no event pulse.
- Count up (`en`=1, `up`=1):
  - `cnt`<MAX: `cnt`<=`cnt`+1.
  - `cnt`==MAX: `cnt`<=0 when SATURATE=0, or holds MAX when SATURATE=1. `ovf`<=1 in both modes.
- Count down (`en`=1, `up`=0):
  - `cnt`>0: `cnt`<=`cnt`-1.
  - `cnt`==0: `cnt`<=MAX when SATURATE=0, or holds 0 when SATURATE=1. `udf`<=1 in both modes.
- `ovf` and `udf` are cleared on any edge where their set condition is false. They are never both high.
- Under saturation with `en` held high, `ovf`/`udf` stay high every cycle the boundary step is attempted.
- Arithmetic is done in WIDTH bits and compared against MAX. When MAX<2**WIDTH-1, `cnt` never exceeds MAX, including after reset and load.
- Direction may change on any cycle. The step uses the `up` value sampled on that edge.
- `cnt` is a register; no other path modifies it.

## Timing
- Latency from `load`/`clear`/`en` to `cnt` update is 1 cycle, visible after the sampling edge.
- `ovf`/`udf` assert in the same cycle that `cnt` shows the wrapped or held value, and last exactly 1 cycle per boundary step.
- `tc` is combinational. It is high during the cycle before the edge on which the boundary step happens, so it is usable as a cascade enable for a following stage.
- Reset mid-count takes effect on the next edge regardless of `en`, `load` or `clear`. The cycle after reset release with `en`=1, `up`=1 gives `cnt`=1.
- There are no multicycle paths and no asynchronous elements.

## Test plan
- Reset and wrap up: WIDTH=4, MAX=9, SATURATE=0. Hold `rst`=0 for 2 edges, then `rst`=1, `en`=1, `up`=1 for 12 edges.
  - Expect `cnt` 0,1..9,0,1,2.
  - `tc`=1 while `cnt`==9.
  - `ovf`=1 for exactly the one cycle `cnt`==0 after 9.
- Wrap down: from `cnt`=0, `en`=1, `up`=0.
  - Expect `cnt`=9 next cycle, `udf`=1 for 1 cycle, `ovf`=0.
- Saturate: SATURATE=1, MAX=9. Load 8, then up for 3 edges.
  - Expect `cnt` 9,9,9.
  - `ovf`=0 on the first edge, 1 on the second and third.
  - Repeat downward from 1: `cnt` 0,0,0, with `udf` high on the second and third edges.
- Priority: set `clear`=1, `load`=1, `din`=5, `en`=1 together → `cnt`=0. Then `load`=1, `en`=1 → `cnt`=5 with no step and `ovf`/`udf`=0.
- Load clamp: MAX=9, `din`=4'hF → `cnt`=9. Also check `cnt_bar`=~`cnt` in every cycle.
- Reset mid-operation: counting up at `cnt`=6, drive `rst`=0 for 1 edge with `en`=1 and `load`=1.
  - Expect `cnt`=0, `ovf`=0, `udf`=0.
  - After `rst`=1, expect `cnt`=1 on the next edge.
